// File: rtl/seqdet_ctrl_if.sv
// Host-side channels of seqdet_ctrl: word input and result output, each valid/ready.
// Macro SEQDET_FIRST_IDX_EN adds the first_hit/first_idx result fields.
interface seqdet_ctrl_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1),
    parameter int unsigned IDX_W  = $clog2(WORD_W)
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  match_cnt;
`ifdef SEQDET_FIRST_IDX_EN
    logic              first_hit;
    logic [IDX_W-1:0]  first_idx;
`endif

    // Host side.
    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef SEQDET_FIRST_IDX_EN
        input  first_hit,
        input  first_idx,
`endif
        input  match_cnt
    );

    // Controller side.
    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef SEQDET_FIRST_IDX_EN
        output first_hit,
        output first_idx,
`endif
        output match_cnt
    );
endinterface

// File: rtl/seqdet_ctrl.sv
// Word-level sequencer for a bit-serial "1011" Mealy detector: clear, shift MSB-first, count hits.
// Macro SEQDET_FIRST_IDX_EN enables capture of the first match position.
module seqdet_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1),
    parameter int unsigned IDX_W  = $clog2(WORD_W)
) (
    input  logic        clk,
    input  logic        rst_n,
    seqdet_ctrl_if.slave bus,
    output logic        det_rst,
    output logic        det_x,
    input  logic        det_y
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLR   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]  bidx_q, bidx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SEQDET_FIRST_IDX_EN
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bidx_d  = bidx_q;
        cnt_d   = cnt_q;
`ifdef SEQDET_FIRST_IDX_EN
        hit_d   = hit_q;
        fidx_d  = fidx_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_word;
                    cnt_d   = '0;
                    bidx_d  = '0;
`ifdef SEQDET_FIRST_IDX_EN
                    hit_d   = 1'b0;
                    fidx_d  = '0;
`endif
                    state_d = CLR;
                end
            end
            CLR: begin
                bidx_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (det_y) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQDET_FIRST_IDX_EN
                    if (!hit_q) begin
                        hit_d  = 1'b1;
                        fidx_d = bidx_q;
                    end
`endif
                end
                sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                bidx_d = bidx_q + IDX_W'(1);
                if (bidx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bidx_q  <= '0;
            cnt_q   <= '0;
`ifdef SEQDET_FIRST_IDX_EN
            hit_q   <= 1'b0;
            fidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bidx_q  <= bidx_d;
            cnt_q   <= cnt_d;
`ifdef SEQDET_FIRST_IDX_EN
            hit_q   <= hit_d;
            fidx_q  <= fidx_d;
`endif
        end
    end

    // The detector is held in clear for the whole of reset, not just in CLR.
    assign det_rst       = ~rst_n | (state_q == CLR);
    assign det_x         = (state_q == SHIFT) & sreg_q[WORD_W-1];
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.match_cnt = cnt_q;
`ifdef SEQDET_FIRST_IDX_EN
    assign bus.first_hit = hit_q;
    assign bus.first_idx = fidx_q;
`endif

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Directed bench for seqdet_ctrl with a behavioural "1011" Mealy detector and a result scoreboard.
// Honours SEQDET_FIRST_IDX_EN when the build defines it.
module tb_seqdet_ctrl;
    localparam int unsigned WORD_W = 8;

    typedef struct {
        logic [3:0] cnt;
        logic       hit;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic det_rst, det_x, det_y;
    logic [1:0] dst;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    seqdet_ctrl_if #(.WORD_W(WORD_W)) bus ();

    seqdet_ctrl #(.WORD_W(WORD_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .det_rst (det_rst),
        .det_x   (det_x),
        .det_y   (det_y)
    );

    always #5 clk = ~clk;

    // Overlapping "1011" Mealy detector; states count the matched prefix length.
    assign det_y = (dst == 2'd3) && det_x;
    always @(posedge clk) begin
        if (det_rst) dst <= 2'd0;
        else begin
            case (dst)
                2'd0:    dst <= det_x ? 2'd1 : 2'd0;
                2'd1:    dst <= det_x ? 2'd1 : 2'd2;
                2'd2:    dst <= det_x ? 2'd3 : 2'd0;
                default: dst <= det_x ? 2'd1 : 2'd2;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_scan(input logic [7:0] w);
        exp_t e;
        int   st;
        logic x;
        e  = '{cnt: 4'd0, hit: 1'b0, idx: 3'd0};
        st = 0;
        for (int i = 0; i < 8; i++) begin
            x = w[7-i];
            if (st == 3 && x) begin
                e.cnt = e.cnt + 4'd1;
                if (!e.hit) begin
                    e.hit = 1'b1;
                    e.idx = i[2:0];
                end
            end
            case (st)
                0:       st = x ? 1 : 0;
                1:       st = x ? 1 : 2;
                2:       st = x ? 3 : 0;
                default: st = x ? 1 : 2;
            endcase
        end
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_cnt"}, 32'(bus.match_cnt), 32'(e.cnt));
`ifdef SEQDET_FIRST_IDX_EN
        check({tag, "_hit"}, 32'(bus.first_hit), 32'(e.hit));
        if (e.hit) check({tag, "_idx"}, 32'(bus.first_idx), 32'(e.idx));
`endif
    endtask

    // Offers a word from a falling edge; returns #1 after the accepting edge.
    task automatic accept_word(input logic [7:0] w, input int max_wait);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(t <= max_wait), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        sb.push_back(ref_scan(w));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_word  = ~w;
    endtask

    task automatic finish_word(input int hold);
        int   lat = 0;
        int   pulses = 0;
        exp_t e;
        bus.out_ready = (hold == 0);
        do begin
            @(negedge clk);
            lat++;
            if (det_rst) pulses++;
            if (lat == 1) begin
                check("clr_det_rst", 32'(det_rst), 32'd1);
                check("clr_det_x", 32'(det_x), 32'd0);
                check("clr_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end while (!bus.out_valid && lat < 50);
        check("latency", 32'(lat), 32'(WORD_W + 2));
        check("det_rst_pulses", 32'(pulses), 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_result("result", e);
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        check("done_det_x", 32'(det_x), 32'd0);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_word  = 8'hA5;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_det_x", 32'(det_x), 32'd0);
                check_result("hold", e);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("post_hold_valid", 32'(bus.out_valid), 32'd0);
            check("post_hold_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_match_cnt", 32'(bus.match_cnt), 32'd0);
        check("rst_det_x", 32'(det_x), 32'd0);
        check("rst_det_rst", 32'(det_rst), 32'd1);
`ifdef SEQDET_FIRST_IDX_EN
        check("rst_first_hit", 32'(bus.first_hit), 32'd0);
        check("rst_first_idx", 32'(bus.first_idx), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_det_rst", 32'(det_rst), 32'd0);

        accept_word(8'b1011_0110, 50);
        finish_word(0);
        accept_word(8'b1011_1011, 0);
        finish_word(0);
        accept_word(8'hFF, 0);
        finish_word(0);
        accept_word(8'h00, 0);
        finish_word(0);
        accept_word(8'b1011_0000, 0);
        finish_word(0);
        accept_word(8'b0000_1011, 0);
        finish_word(0);

        accept_word(8'b1011_0110, 0);
        finish_word(5);

        for (int k = 0; k < 4; k++) begin
            accept_word(8'($urandom_range(0, 255)), 1);
            finish_word(0);
        end

        // Abort at SHIFT bidx=4 (cycle 6 after accept); the partial result is discarded.
        accept_word(8'b1011_0110, 1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_match_cnt", 32'(bus.match_cnt), 32'd0);
        check("abort_det_rst", 32'(det_rst), 32'd1);
        check("abort_det_x", 32'(det_x), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_det_rst_held", 32'(det_rst), 32'd1);
        rst_n = 1'b1;
        #1;
        check("release_det_rst", 32'(det_rst), 32'd0);
        accept_word(8'b1011_0110, 0);
        finish_word(0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
